// File: rtl/disp_sched_if.sv
// disp_sched_if -- datapath and result bus of the disparity scheduler.
//
// Signals:
//   col_index, disp_grp, sad_req   scheduler -> datapath request
//   sad_valid, sad_in              datapath -> scheduler lane SADs
//   out_disp, out_valid, out_ready result handshake
//   out_sad                        winning SAD, only with DISP_SCHED_MIN_SAD_EN
// Modports: master = scheduler side, slave = datapath/consumer side.
interface disp_sched_if #(
  parameter int COL_BITS   = 10,
  parameter int GRP_BITS   = 3,
  parameter int DISP_BITS  = 6,
  parameter int SAD_BITS   = 16,
  parameter int DISP_PARTS = 8
);
  logic [COL_BITS-1:0]            col_index;
  logic [GRP_BITS-1:0]            disp_grp;
  logic                           sad_req;
  logic                           sad_valid;
  logic [DISP_PARTS*SAD_BITS-1:0] sad_in;
  logic [DISP_BITS-1:0]           out_disp;
  logic                           out_valid;
  logic                           out_ready;
`ifdef DISP_SCHED_MIN_SAD_EN
  logic [SAD_BITS-1:0]            out_sad;
`endif

  modport master (
    output
`ifdef DISP_SCHED_MIN_SAD_EN
      out_sad,
`endif
      col_index, disp_grp, sad_req, out_disp, out_valid,
    input  sad_valid, sad_in, out_ready
  );

  modport slave (
    input
`ifdef DISP_SCHED_MIN_SAD_EN
      out_sad,
`endif
      col_index, disp_grp, sad_req, out_disp, out_valid,
    output sad_valid, sad_in, out_ready
  );
endinterface

// File: rtl/disp_sched.sv
// disp_sched -- per-pixel disparity search scheduler.
//
// For each column of a row, requests the G disparity groups one at a time
// from the SAD datapath, keeps the running minimum SAD over the lanes that
// are geometrically possible (d <= column), and emits the winning disparity
// on a valid/ready handshake. After the last column it raises done and idles.
//
// Ports:
//   clk    sole clock, posedge
//   rst    synchronous active-high reset
//   start  begin a row sweep when idle (ignored while busy)
//   busy   high in every state except IDLE
//   done   row complete, held until the next accepted start
//   bus    disp_sched_if.master: col_index, disp_grp, sad_req, sad_valid,
//          sad_in, out_disp, out_valid, out_ready (+ out_sad)
//
// Optional feature: define DISP_SCHED_MIN_SAD_EN to add bus.out_sad, the
// winning SAD value, valid with out_valid and reset to all ones.
module disp_sched #(
  parameter int MAX_DISP   = 64,
  parameter int DISP_PARTS = 8,
  parameter int IMG_W      = 640,
  parameter int SAD_BITS   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  disp_sched_if.master  bus
);
  localparam int G         = MAX_DISP / DISP_PARTS;
  localparam int DISP_BITS = $clog2(MAX_DISP);
  localparam int GRP_BITS  = ($clog2(G) > 1) ? $clog2(G) : 1;
  localparam int COL_BITS  = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t               state_q, state_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [GRP_BITS-1:0]  grp_q, grp_d;
  logic [SAD_BITS-1:0]  best_sad_q, best_sad_d;
  logic [DISP_BITS-1:0] best_disp_q, best_disp_d;
  logic                 done_q, done_d;
  logic                 sad_req_q, sad_req_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  // Running minimum after folding in the current group's lanes.
  logic [SAD_BITS-1:0]  scan_sad;
  logic [DISP_BITS-1:0] scan_disp;

  // Lanes scanned in ascending disparity with strict less-than, so the lowest
  // disparity wins ties both within a group and across groups.
  always_comb begin
    scan_sad  = best_sad_q;
    scan_disp = best_disp_q;
    for (int l = 0; l < DISP_PARTS; l++) begin
      if ((int'(grp_q) * DISP_PARTS + l) <= int'(col_q) &&
          bus.sad_in[l*SAD_BITS +: SAD_BITS] < scan_sad) begin
        scan_sad  = bus.sad_in[l*SAD_BITS +: SAD_BITS];
        scan_disp = DISP_BITS'(int'(grp_q) * DISP_PARTS + l);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    grp_d       = grp_q;
    best_sad_d  = best_sad_q;
    best_disp_d = best_disp_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          col_d       = '0;
          grp_d       = '0;
          done_d      = 1'b0;
          best_sad_d  = '1;
          best_disp_d = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.sad_valid) begin
          best_sad_d  = scan_sad;
          best_disp_d = scan_disp;
          if (int'(grp_q) == G - 1) begin
            state_d = EMIT;
          end else begin
            grp_d   = grp_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          grp_d = '0;
          if (int'(col_q) == IMG_W - 1) begin
            // Last column: keep the result visible, wrap column, go idle.
            col_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            col_d       = col_q + 1'b1;
            best_sad_d  = '1;
            best_disp_d = '0;
            state_d     = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they come out of flops.
    sad_req_d   = (state_d == ISSUE);
    out_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      grp_q       <= '0;
      best_sad_q  <= '1;
      best_disp_q <= '0;
      done_q      <= 1'b0;
      sad_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      grp_q       <= grp_d;
      best_sad_q  <= best_sad_d;
      best_disp_q <= best_disp_d;
      done_q      <= done_d;
      sad_req_q   <= sad_req_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.col_index = col_q;
  assign bus.disp_grp  = grp_q;
  assign bus.sad_req   = sad_req_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_disp  = best_disp_q;
`ifdef DISP_SCHED_MIN_SAD_EN
  assign bus.out_sad   = best_sad_q;
`endif
endmodule
